// File: rtl/resolution_text_renderer.sv
// Serialises one 80-bit glyph row per text-box line into a per-pixel "text on" flag,
// magnified by SCALE in both directions and placed at column X0, line Y0.
module resolution_text_renderer #(
  parameter int X0    = 16,
  parameter int Y0    = 16,
  parameter int SCALE = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        line_start,
  input  logic [11:0] line,
  input  logic [11:0] counterX,
  output logic [3:0]  rom_addr,
  input  logic [79:0] rom_q,
  output logic        pixel_on,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_LATCH  = 3'd2,
    S_WAIT_X = 3'd3,
    S_SHIFT  = 3'd4
  } state_t;

  localparam logic [11:0] X_START    = 12'(X0);
  localparam logic [11:0] Y_FIRST    = 12'(Y0);
  localparam logic [11:0] Y_LIMIT    = 12'(Y0 + 16 * SCALE);
  localparam logic [2:0]  SUB_MAX    = 3'(SCALE - 1);
  localparam logic [6:0]  GLYPH_BITS = 7'd80;

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_row, w_row_nxt;
  logic [2:0]  r_rep, w_rep_nxt;
  logic [79:0] r_sr, w_sr_nxt;
  logic [6:0]  r_bitcnt, w_bitcnt_nxt;
  logic [2:0]  r_sub, w_sub_nxt;
  logic [3:0]  r_rom_addr, w_rom_addr_nxt;
  logic        r_pixel_on, w_pixel_nxt;
  logic        r_busy;
  logic        w_in_box;
  logic        w_emit;

  assign w_in_box = (line >= Y_FIRST) && (line < Y_LIMIT);

  // Next-state, row tracking and pixel serialisation
  always_comb begin
    w_state_nxt    = r_state;
    w_row_nxt      = r_row;
    w_rep_nxt      = r_rep;
    w_sr_nxt       = r_sr;
    w_bitcnt_nxt   = r_bitcnt;
    w_sub_nxt      = r_sub;
    w_rom_addr_nxt = r_rom_addr;
    w_pixel_nxt    = 1'b0;
    w_emit         = 1'b0;

    // A line_start always wins: any line in progress is abandoned.
    if (line_start) begin
      if (w_in_box) begin
        w_state_nxt = S_FETCH;
        if (line == Y_FIRST) begin
          w_row_nxt = 4'd0;
          w_rep_nxt = 3'd0;
        end else if (r_rep == SUB_MAX) begin
          w_rep_nxt = 3'd0;
          w_row_nxt = r_row + 4'd1;
        end else begin
          w_rep_nxt = r_rep + 3'd1;
        end
        w_rom_addr_nxt = w_row_nxt;
      end else begin
        w_state_nxt = S_IDLE;
      end
    end else begin
      case (r_state)
        S_IDLE:   w_state_nxt = S_IDLE;
        S_FETCH:  w_state_nxt = S_LATCH;
        S_LATCH: begin
          w_sr_nxt     = rom_q;
          w_bitcnt_nxt = GLYPH_BITS;
          w_sub_nxt    = 3'd0;
          w_state_nxt  = S_WAIT_X;
        end
        // The X0 cycle already emits so the flag lands one cycle after its column.
        S_WAIT_X: begin
          if (counterX == X_START) begin
            w_emit = 1'b1;
          end else begin
            w_emit = 1'b0;
          end
        end
        S_SHIFT:  w_emit = 1'b1;
        default:  w_state_nxt = S_IDLE;
      endcase

      if (w_emit) begin
        w_pixel_nxt = r_sr[79];
        if (r_sub == SUB_MAX) begin
          w_sub_nxt    = 3'd0;
          w_sr_nxt     = {r_sr[78:0], 1'b0};
          w_bitcnt_nxt = r_bitcnt - 7'd1;
          w_state_nxt  = (r_bitcnt == 7'd1) ? S_IDLE : S_SHIFT;
        end else begin
          w_sub_nxt   = r_sub + 3'd1;
          w_state_nxt = S_SHIFT;
        end
      end else begin
        w_pixel_nxt = 1'b0;
      end
    end
  end

  // State and datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_row      <= 4'd0;
      r_rep      <= 3'd0;
      r_sr       <= 80'd0;
      r_bitcnt   <= 7'd0;
      r_sub      <= 3'd0;
      r_rom_addr <= 4'd0;
      r_pixel_on <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_row      <= w_row_nxt;
      r_rep      <= w_rep_nxt;
      r_sr       <= w_sr_nxt;
      r_bitcnt   <= w_bitcnt_nxt;
      r_sub      <= w_sub_nxt;
      r_rom_addr <= w_rom_addr_nxt;
      r_pixel_on <= w_pixel_nxt;
      r_busy     <= (w_state_nxt != S_IDLE);
    end
  end

  assign rom_addr = r_rom_addr;
  assign pixel_on = r_pixel_on;
  assign busy     = r_busy;

endmodule

// File: tb/tb_resolution_text_renderer.sv
// Three renderers (SCALE 1, 2, 3; X0=100, Y0=50) share one video timing stream;
// a column-based scoreboard predicts pixel_on, busy and rom_addr for every cycle.
module tb_resolution_text_renderer;

  localparam int X0 = 100;
  localparam int Y0 = 50;
  localparam int H  = 360;

  typedef struct packed {
    logic [2:0]      pix;
    logic [2:0]      busy;
    logic [2:0][3:0] addr;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        line_start = 1'b0;
  logic [11:0] line = 12'd0;
  logic [11:0] counterX = 12'd0;
  logic [3:0]  a0, a1, a2;
  logic [79:0] q0, q1, q2;
  logic [2:0]  w_pix, w_busy;

  logic [79:0] rom [16];
  exp_t        sb [$];
  bit          live [3];
  bit          armed [3];
  int          row [3];
  logic [3:0]  eaddr [3];
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clock = ~clock;

  resolution_text_renderer #(.X0(X0), .Y0(Y0), .SCALE(1)) u_s1 (
    .clock(clock), .reset(reset), .line_start(line_start), .line(line), .counterX(counterX),
    .rom_addr(a0), .rom_q(q0), .pixel_on(w_pix[0]), .busy(w_busy[0]));
  resolution_text_renderer #(.X0(X0), .Y0(Y0), .SCALE(2)) u_s2 (
    .clock(clock), .reset(reset), .line_start(line_start), .line(line), .counterX(counterX),
    .rom_addr(a1), .rom_q(q1), .pixel_on(w_pix[1]), .busy(w_busy[1]));
  resolution_text_renderer #(.X0(X0), .Y0(Y0), .SCALE(3)) u_s3 (
    .clock(clock), .reset(reset), .line_start(line_start), .line(line), .counterX(counterX),
    .rom_addr(a2), .rom_q(q2), .pixel_on(w_pix[2]), .busy(w_busy[2]));

  // Registered character ROMs, one per renderer
  always @(posedge clock) begin
    q0 <= rom[a0];
    q1 <= rom[a1];
    q2 <= rom[a2];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  // One pixel clock: check the previous prediction, drive inputs, predict the result.
  task automatic cyc(input bit ls, input int ln, input int cx, input bit rst);
    exp_t        e;
    logic [79:0] wd;
    logic [3:0]  aobs;
    int          s, k;
    @(negedge clock);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      for (int d = 0; d < 3; d++) begin
        aobs = (d == 0) ? a0 : ((d == 1) ? a1 : a2);
        check($sformatf("pix_s%0d", d + 1), {31'd0, w_pix[d]}, {31'd0, e.pix[d]});
        check($sformatf("busy_s%0d", d + 1), {31'd0, w_busy[d]}, {31'd0, e.busy[d]});
        check($sformatf("addr_s%0d", d + 1), {28'd0, aobs}, {28'd0, e.addr[d]});
      end
    end
    reset      = rst;
    line_start = ls;
    line       = 12'(ln);
    counterX   = 12'(cx);
    for (int d = 0; d < 3; d++) begin
      s = d + 1;
      if (rst) begin
        live[d] = 1'b0; armed[d] = 1'b0; eaddr[d] = 4'd0;
        e.pix[d] = 1'b0; e.busy[d] = 1'b0;
      end else if (ls) begin
        armed[d] = 1'b0;
        e.pix[d] = 1'b0;
        if (ln >= Y0 && ln < Y0 + 16 * s) begin
          live[d] = 1'b1; row[d] = (ln - Y0) / s; eaddr[d] = 4'(row[d]); e.busy[d] = 1'b1;
        end else begin
          live[d] = 1'b0; e.busy[d] = 1'b0;
        end
      end else if (live[d]) begin
        if (cx == X0) armed[d] = 1'b1;
        if (armed[d]) begin
          k = cx - X0;
          wd = rom[row[d]];
          e.pix[d] = wd[79 - k / s];
          if (k == 80 * s - 1) begin
            live[d] = 1'b0; armed[d] = 1'b0; e.busy[d] = 1'b0;
          end else begin
            e.busy[d] = 1'b1;
          end
        end else begin
          e.pix[d] = 1'b0; e.busy[d] = 1'b1;
        end
      end else begin
        e.pix[d] = 1'b0; e.busy[d] = 1'b0;
      end
      e.addr[d] = eaddr[d];
    end
    sb.push_back(e);
  endtask

  // line_start at column start_x, then columns 1..stop_x-1 (X0 optionally skipped).
  task automatic run_line(input int ln, input int start_x, input int stop_x,
                          input bit skip, input int rst_at);
    cyc(1'b1, ln, start_x, 1'b0);
    for (int x = 1; x < stop_x; x++) begin
      if (!(skip && x == X0)) cyc(1'b0, ln, x, x == rst_at);
    end
  endtask

  initial begin
    rom[0] = 80'h8000_0000_0000_0000_0001;
    rom[1] = {80{1'b1}};
    for (int r = 2; r < 16; r++) rom[r] = {$urandom, $urandom, 16'($urandom)};
    for (int d = 0; d < 3; d++) begin
      live[d] = 1'b0; armed[d] = 1'b0; row[d] = 0; eaddr[d] = 4'd0;
    end

    for (int i = 0; i < 3; i++) cyc(1'b0, 0, 0, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b0, 0, 0, 1'b0);

    // Short frame with a reset in the middle of line 51 (all-ones row for SCALE 1)
    run_line(50, 0, H, 1'b0, 0);
    run_line(51, 0, H, 1'b0, X0 + 10);
    run_line(48, 0, H, 1'b0, 0);

    // Full frame: line 60 skips X0, line 70 is aborted at X0+40 by line 71's line_start
    for (int ln = 48; ln < 100; ln++) begin
      if (ln == 60)      run_line(ln, 0, H, 1'b1, 0);
      else if (ln == 70) run_line(ln, 0, X0 + 40, 1'b0, 0);
      else if (ln == 71) run_line(ln, X0 + 40, H, 1'b0, 0);
      else               run_line(ln, 0, H, 1'b0, 0);
    end

    for (int i = 0; i < 4; i++) cyc(1'b0, 0, 0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/resolution_text_renderer.md
# resolution_text_renderer

Downstream consumer of the resolution character ROM: it drives the ROM row address and turns each returned 80-bit glyph row into a serial per-pixel "text on" flag. The flag is scaled by an integer factor in both directions and positioned at a fixed box origin. It sits between the video timing counters and the pixel mixer, which uses `pixel_on` to overlay the resolution label ("1080p", "720p", "VGA") onto the output image.

## Interface
Parameters:
- `X0`, default 16: first active pixel column of the text box.
- `Y0`, default 16: first active line of the text box.
- `SCALE`, default 2: integer magnification (legal range 1..8); each glyph bit covers SCALE×SCALE pixels.

Ports:
- `clock`, in, 1: pixel clock. Single clock domain.
- `reset`, in, 1: synchronous, active-high reset.
- `line_start`, in, 1: one-cycle pulse in horizontal blanking, before the first active pixel of each line.
- `line`, in, 12: line number of the upcoming line; sampled only when `line_start` = 1.
- `counterX`, in, 12: current pixel column, valid every cycle.
- `rom_addr`, out, 4: row address to the ROM `addr` input.
- `rom_q`, in, 80: ROM data; bit 79 is the leftmost pixel. Valid one cycle after `rom_addr` is presented (registered ROM).
- `pixel_on`, out, 1: registered; 1 means the text foreground covers this pixel.
- `busy`, out, 1: high whenever the FSM is not IDLE.

## Operation
- Box size: 80·SCALE columns by 16·SCALE lines. A line is in the box when Y0 ≤ `line` < Y0+16·SCALE.
- Row tracking: counters `row` (4 bit) and `rep` (3 bit).
  - On a `line_start` with `line` == Y0: row=0, rep=0.
  - On each later in-box `line_start`: rep increments. When rep reaches SCALE−1 and then increments, it wraps to 0 and row increments.
- FSM states: IDLE, FETCH, LATCH, WAIT_X, SHIFT.
  - IDLE: on an in-box `line_start` → FETCH. An out-of-box `line_start` stays in IDLE with no ROM access.
  - FETCH (1 cycle): `rom_addr` = row → LATCH.
  - LATCH (1 cycle): `rom_q` is loaded into an 80-bit shift register; bit count = 80, sub-pixel count = 0 → WAIT_X.
  - WAIT_X: when `counterX` == X0 → SHIFT.
  - SHIFT: output MSB of the shift register each cycle. The sub-pixel counter increments; when it reaches SCALE−1 it resets, the register shifts left by 1, and the bit count decrements. When the bit count reaches 0 after its last sub-pixel → IDLE.
- `line_start` in any non-IDLE state aborts the current line and is handled exactly as if received in IDLE, with the same cycle re-evaluating the new line.
- `rom_addr` holds its last value outside FETCH.
- Exactly 80·SCALE pixels are emitted per box line. Pixels left of X0 and right of X0+80·SCALE−1 are 0.
- If `counterX` never reaches X0 before the next `line_start`, nothing is emitted for that line.

## Timing
- Reset values: FSM=IDLE, `pixel_on`=0, `busy`=0, `rom_addr`=0, row=0, rep=0, shift register=0.
- Reset asserted mid-line: the next cycle is in IDLE with `pixel_on`=0. No partial output resumes afterwards.
- Fetch cost: `line_start` in cycle t → FETCH in t+1 → LATCH in t+2 → WAIT_X from t+3. The horizontal blanking gap between `line_start` and the X0 pixel must be ≥ 3 cycles.
- Output latency: `pixel_on` for column X0+k appears in the cycle after `counterX` == X0+k. It equals bit (79 − k/SCALE) of the fetched row, using integer division.
- Last foreground pixel covers column X0+80·SCALE−1. `pixel_on`=0 from the following cycle.
- `busy` falls in the cycle after the last SHIFT cycle.

## Test plan
- Reset mid-SHIFT (SCALE=1, row of all 1s, reset at X0+10) → `pixel_on`=0 next cycle; FSM in IDLE; no output until the next in-box `line_start`.
- SCALE=1, X0=100, Y0=50, `rom_q`=80'h8000…0001 on line 50 → `rom_addr`=0 at t+1; `pixel_on`=1 only in the cycles after `counterX`=100 and `counterX`=179.
- SCALE=2, Y0=50: lines 50,51 → `rom_addr`=0; lines 52,53 → 1; line 81 → 15; line 82 → no fetch, `busy` stays 0.
- SCALE=3, `rom_q` bit79=1, bit78=0 → `pixel_on`=1 for columns X0..X0+2 and 0 for X0+3..X0+5. The total SHIFT length is 240 cycles.
- `line_start` injected while in SHIFT at column X0+40 → abort; FETCH on the next cycle with the new row; no stale pixels after the new `line_start`.
- `counterX` sweep that skips X0 (jumps 99→101) → no `pixel_on` that line; the FSM leaves WAIT_X on the next `line_start`.
